// File: rtl/buffer_arb_pkg.sv
// Shared definitions for the endpoint data buffer arbiter.
// Contents: buffer geometry (DEPTH, ADDR_W, OCC_W) and the ownership FSM state type.
package buffer_arb_pkg;
  localparam int DEPTH  = 64;
  localparam int ADDR_W = 6;
  localparam int OCC_W  = 7;

  // IDLE: empty, no owner. H2E: USB writes / AHB reads. E2H: AHB writes / USB reads.
  typedef enum logic [1:0] {IDLE, H2E, E2H} arb_state_e;
endpackage

// File: rtl/buffer_ptr_tracker.sv
// Write/read pointers and occupancy for the 64-byte endpoint buffer.
// Ports:
//   clk, n_rst         clock, asynchronous active-low reset
//   inc_w, inc_r       advance write / read pointer this edge (granted store / get)
//   sync_clr           synchronous discard: pointers and occupancy to 0
//   wr_ptr, rd_ptr     current pointers (wrap by natural overflow)
//   occupancy          bytes held, 0..DEPTH
//   full, empty        occupancy == DEPTH / occupancy == 0
module buffer_ptr_tracker
  import buffer_arb_pkg::*;
(
  input  logic              clk,
  input  logic              n_rst,
  input  logic              inc_w,
  input  logic              inc_r,
  input  logic              sync_clr,
  output logic [ADDR_W-1:0] wr_ptr,
  output logic [ADDR_W-1:0] rd_ptr,
  output logic [OCC_W-1:0]  occupancy,
  output logic              full,
  output logic              empty
);
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      occupancy <= '0;
    end else if (sync_clr) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      occupancy <= '0;
    end else begin
      wr_ptr <= wr_ptr + ADDR_W'(inc_w);
      rd_ptr <= rd_ptr + ADDR_W'(inc_r);
      // Concurrent store+get leaves occupancy unchanged.
      case ({inc_w, inc_r})
        2'b10:   occupancy <= occupancy + OCC_W'(1);
        2'b01:   occupancy <= occupancy - OCC_W'(1);
        default: occupancy <= occupancy;
      endcase
    end
  end

  assign full  = (occupancy == OCC_W'(DEPTH));
  assign empty = (occupancy == '0);
endmodule

// File: rtl/buffer_access_arbiter.sv
// Arbiter owning the write and read ports of the 64-byte USB endpoint buffer.
// One transfer direction per buffer fill: the first granted store picks the
// writer (USB -> H2E, AHB -> E2H); the opposite side is the only reader until
// the buffer drains back to empty.
// Ports:
//   clk, n_rst                    clock, asynchronous active-low reset
//   ahb_store_req/data, ahb_get_req   AHB side byte write / read requests
//   usb_store_req/data, usb_get_req   USB side byte write / read requests
//   clear, flush                  synchronous discard (flush also clears err_count)
//   *_gnt                         same-cycle grants
//   mem_we/waddr/wdata, mem_raddr buffer RAM ports (read data one cycle after get)
//   buffer_occupancy, full, empty fill state
//   dir_err, ovf_err, unf_err     one-cycle refusal pulses
//   err_count                     saturating error counter, only with BUFFER_ARB_ERR_CNT_EN
module buffer_access_arbiter
  import buffer_arb_pkg::*;
(
  input  logic              clk,
  input  logic              n_rst,
  input  logic              ahb_store_req,
  input  logic [7:0]        ahb_store_data,
  input  logic              ahb_get_req,
  input  logic              usb_store_req,
  input  logic [7:0]        usb_store_data,
  input  logic              usb_get_req,
  input  logic              clear,
  input  logic              flush,
  output logic              ahb_store_gnt,
  output logic              ahb_get_gnt,
  output logic              usb_store_gnt,
  output logic              usb_get_gnt,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_waddr,
  output logic [7:0]        mem_wdata,
  output logic [ADDR_W-1:0] mem_raddr,
  output logic [OCC_W-1:0]  buffer_occupancy,
  output logic              full,
  output logic              empty,
  output logic              dir_err,
  output logic              ovf_err,
`ifdef BUFFER_ARB_ERR_CNT_EN
  output logic [7:0]        err_count,
`endif
  output logic              unf_err
);
  arb_state_e state;
  logic       sync_clr, kill, store_gnt, get_gnt;

  assign sync_clr = clear | flush;
  // Reset gates the combinational grants so an in-flight grant drops at once.
  assign kill     = sync_clr | ~n_rst;

  always_comb begin
    usb_store_gnt = 1'b0;
    ahb_store_gnt = 1'b0;
    usb_get_gnt   = 1'b0;
    ahb_get_gnt   = 1'b0;
    dir_err       = 1'b0;
    ovf_err       = 1'b0;
    unf_err       = 1'b0;
    if (!kill) begin
      case (state)
        IDLE: begin
          // USB store wins a tie; the losing AHB store is a direction error.
          if (usb_store_req) begin
            usb_store_gnt = 1'b1;
            dir_err       = ahb_store_req;
          end else if (ahb_store_req) begin
            ahb_store_gnt = 1'b1;
          end
          unf_err = ahb_get_req | usb_get_req;
        end
        H2E: begin
          usb_store_gnt = usb_store_req & ~full;
          ovf_err       = usb_store_req & full;
          ahb_get_gnt   = ahb_get_req & ~empty;
          unf_err       = ahb_get_req & empty;
          dir_err       = ahb_store_req | usb_get_req;
        end
        E2H: begin
          ahb_store_gnt = ahb_store_req & ~full;
          ovf_err       = ahb_store_req & full;
          usb_get_gnt   = usb_get_req & ~empty;
          unf_err       = usb_get_req & empty;
          dir_err       = usb_store_req | ahb_get_req;
        end
        default: ;
      endcase
    end
  end

  assign store_gnt = usb_store_gnt | ahb_store_gnt;
  assign get_gnt   = usb_get_gnt | ahb_get_gnt;
  assign mem_we    = store_gnt;
  assign mem_wdata = usb_store_gnt ? usb_store_data :
                     ahb_store_gnt ? ahb_store_data : 8'h00;

  buffer_ptr_tracker u_ptr (
    .clk       (clk),
    .n_rst     (n_rst),
    .inc_w     (store_gnt),
    .inc_r     (get_gnt),
    .sync_clr  (sync_clr),
    .wr_ptr    (mem_waddr),
    .rd_ptr    (mem_raddr),
    .occupancy (buffer_occupancy),
    .full      (full),
    .empty     (empty)
  );

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state <= IDLE;
    end else if (sync_clr) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (usb_store_gnt)      state <= H2E;
          else if (ahb_store_gnt) state <= E2H;
        end
        H2E, E2H: begin
          // Release ownership when the last byte leaves and nothing refills it.
          if (get_gnt && !store_gnt && buffer_occupancy == OCC_W'(1)) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef BUFFER_ARB_ERR_CNT_EN
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst)                                    err_count <= 8'h00;
    else if (flush)                                err_count <= 8'h00;
    else if ((dir_err | ovf_err | unf_err) && err_count != 8'hFF)
                                                   err_count <= err_count + 8'h01;
  end
`endif
endmodule
